// File: rtl/pixel_frame_rx_pkg.sv
// Shared definitions for the pixel frame receive path: pixel width,
// receiver state encoding and a ceiling-log2 helper for sizing counters.
package pixel_pkg;

  localparam int PIXEL_W = 8;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } rx_state_e;

  // Ceiling log2, never below 1 so a one-entry buffer still gets an address bit
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pixel_frame_rx_if.sv
// AXI-Stream style pixel link: source drives valid/tlast/tdata, sink drives ready.
interface pixel_frame_rx_if import pixel_pkg::*; ();

  logic               valid;
  logic               ready;
  logic               tlast;
  logic [PIXEL_W-1:0] tdata;

  modport master (output valid, output tlast, output tdata, input ready);
  modport slave  (input valid, input tlast, input tdata, output ready);

endinterface

// File: rtl/pixel_frame_ram.sv
// Single-write, single-read frame buffer with a registered read port.
// A read that collides with a write to the same address returns the old data.
module pixel_frame_ram import pixel_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int AW    = log2(DEPTH),
  parameter int DW    = PIXEL_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] rd_data_d;

  // Combinational array lookup feeding the read register
  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  // Storage array is never reset; only written on accepted pixels
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Read register, cleared by reset so the port starts at a known value
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pixel_frame_rx.sv
// Frame sink: receives one ROWS x COLUMNS frame, checks tlast framing,
// buffers the pixels and reports min/max/sum, holding the frame until acked.
module pixel_frame_rx import pixel_pkg::*; #(
  parameter  int ROWS    = 4,
  parameter  int COLUMNS = 4,
  localparam int PIXELS  = ROWS * COLUMNS,
  localparam int ABITS   = log2(PIXELS),
  localparam int SBITS   = PIXEL_W + ABITS
) (
  input  logic                clk,
  input  logic                rst,
  pixel_frame_rx_if.slave     axis,
  output logic                frame_done,
  output logic                frame_err,
  input  logic                frame_ack,
  input  logic [ABITS-1:0]    rd_addr,
  output logic [PIXEL_W-1:0]  rd_data,
  output logic [PIXEL_W-1:0]  pix_min,
  output logic [PIXEL_W-1:0]  pix_max,
  output logic [SBITS-1:0]    pix_sum,
  output logic [7:0]          err_count
);

  rx_state_e          state_q, state_d;
  logic [ABITS-1:0]   wr_cnt_q, wr_cnt_d;
  logic [PIXEL_W-1:0] run_min_q, run_min_d;
  logic [PIXEL_W-1:0] run_max_q, run_max_d;
  logic [SBITS-1:0]   run_sum_q, run_sum_d;
  logic [PIXEL_W-1:0] pix_min_q, pix_min_d;
  logic [PIXEL_W-1:0] pix_max_q, pix_max_d;
  logic [SBITS-1:0]   pix_sum_q, pix_sum_d;
  logic [7:0]         err_count_q, err_count_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_err_q, frame_err_d;

  logic               accept;
  logic               last_slot;
  logic               buf_we;
  logic [7:0]         err_inc;
  logic [PIXEL_W-1:0] beat_min;
  logic [PIXEL_W-1:0] beat_max;
  logic [SBITS-1:0]   beat_sum;

  // Ready comes from registered state only; reset forces it low
  assign axis.ready = (state_q != HOLD) && !rst;
  assign accept     = axis.valid && axis.ready;
  assign last_slot  = (wr_cnt_q == ABITS'(PIXELS - 1));
  assign buf_we     = accept && (state_q == RECV);
  assign err_inc    = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

  // Running statistics including the pixel currently on the bus
  always_comb begin
    beat_min = (axis.tdata < run_min_q) ? axis.tdata : run_min_q;
    beat_max = (axis.tdata > run_max_q) ? axis.tdata : run_max_q;
    beat_sum = run_sum_q + SBITS'(axis.tdata);
  end

  // Next-state, counter and statistics decisions for each accepted beat
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    run_min_d    = run_min_q;
    run_max_d    = run_max_q;
    run_sum_d    = run_sum_q;
    pix_min_d    = pix_min_q;
    pix_max_d    = pix_max_q;
    pix_sum_d    = pix_sum_q;
    err_count_d  = err_count_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      RECV: begin
        if (accept) begin
          if (axis.tlast || last_slot) begin
            wr_cnt_d  = '0;
            run_min_d = '1;
            run_max_d = '0;
            run_sum_d = '0;
            if (axis.tlast && last_slot) begin
              pix_min_d    = beat_min;
              pix_max_d    = beat_max;
              pix_sum_d    = beat_sum;
              frame_done_d = 1'b1;
              state_d      = HOLD;
            end else begin
              frame_err_d = 1'b1;
              err_count_d = err_inc;
              if (!axis.tlast) state_d = DRAIN;
            end
          end else begin
            wr_cnt_d  = wr_cnt_q + 1'b1;
            run_min_d = beat_min;
            run_max_d = beat_max;
            run_sum_d = beat_sum;
          end
        end
      end
      HOLD: begin
        if (frame_ack) state_d = RECV;
      end
      DRAIN: begin
        if (accept && axis.tlast) state_d = RECV;
      end
      default: state_d = RECV;
    endcase
  end

  // State, counters and reported statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RECV;
      wr_cnt_q     <= '0;
      run_min_q    <= '1;
      run_max_q    <= '0;
      run_sum_q    <= '0;
      pix_min_q    <= '0;
      pix_max_q    <= '0;
      pix_sum_q    <= '0;
      err_count_q  <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      run_min_q    <= run_min_d;
      run_max_q    <= run_max_d;
      run_sum_q    <= run_sum_d;
      pix_min_q    <= pix_min_d;
      pix_max_q    <= pix_max_d;
      pix_sum_q    <= pix_sum_d;
      err_count_q  <= err_count_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  pixel_frame_ram #(
    .DEPTH (PIXELS),
    .AW    (ABITS),
    .DW    (PIXEL_W)
  ) u_frame_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (buf_we),
    .wr_addr (wr_cnt_q),
    .wr_data (axis.tdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign pix_min    = pix_min_q;
  assign pix_max    = pix_max_q;
  assign pix_sum    = pix_sum_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_pixel_frame_rx.sv
// Directed bench for pixel_frame_rx with a 4x4 frame.
module tb_pixel_frame_rx;

  logic        clk;
  logic        rst;
  logic        frame_ack;
  logic [3:0]  rd_addr;
  logic        frame_done;
  logic        frame_err;
  logic [7:0]  rd_data;
  logic [7:0]  pix_min;
  logic [7:0]  pix_max;
  logic [11:0] pix_sum;
  logic [7:0]  err_count;

  int n_cmp;
  int n_bad;

  pixel_frame_rx_if axis ();

  pixel_frame_rx #(.ROWS(4), .COLUMNS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .axis       (axis),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .frame_ack  (frame_ack),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .pix_min    (pix_min),
    .pix_max    (pix_max),
    .pix_sum    (pix_sum),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Present one beat and hold it until it is taken (bounded)
  task automatic send_beat(input logic [7:0] d, input logic l);
    int waited;
    axis.valid = 1'b1;
    axis.tdata = d;
    axis.tlast = l;
    waited = 0;
    while (axis.ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL beat_accept: ready=%b required=1 within 50 cycles", axis.ready);
    end else begin
      @(posedge clk); #1;
    end
    axis.valid = 1'b0;
    axis.tlast = 1'b0;
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
  endtask

  task automatic read_buf(input logic [3:0] a);
    rd_addr = a;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (axis.ready !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ready: got %b want 0", axis.ready); end
    n_cmp++; if ({frame_done, frame_err} !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_pulses: got %b want 00", {frame_done, frame_err}); end
    n_cmp++; if ({pix_min, pix_max, pix_sum, err_count, rd_data} !== 44'd0) begin n_bad++; $display("[TB] FAIL reset_outputs: min=%h max=%h sum=%0d err=%0d rd=%h want all 0", pix_min, pix_max, pix_sum, err_count, rd_data); end
    rst = 1'b0;
    #1;
    n_cmp++; if (axis.ready !== 1'b1) begin n_bad++; $display("[TB] FAIL post_reset_ready: got %b want 1", axis.ready); end
  endtask

  task automatic test_good_frame();
    for (int i = 0; i < 16; i++) send_beat(8'(i), i == 15);
    n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("[TB] FAIL good_done: got %b want 1", frame_done); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("[TB] FAIL good_err: got %b want 0", frame_err); end
    n_cmp++; if (pix_min !== 8'd0 || pix_max !== 8'd15 || pix_sum !== 12'd120) begin n_bad++; $display("[TB] FAIL good_stats: min=%0d max=%0d sum=%0d want 0/15/120", pix_min, pix_max, pix_sum); end
    n_cmp++; if (axis.ready !== 1'b0) begin n_bad++; $display("[TB] FAIL good_hold_ready: got %b want 0", axis.ready); end
    read_buf(4'd7);
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("[TB] FAIL good_done_width: got %b want 0", frame_done); end
    n_cmp++; if (rd_data !== 8'd7) begin n_bad++; $display("[TB] FAIL good_rd7: got %0d want 7", rd_data); end
  endtask

  task automatic test_backpressure();
    axis.valid = 1'b1;
    axis.tdata = 8'h33;
    axis.tlast = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (axis.ready !== 1'b0 || frame_done !== 1'b0 || frame_err !== 1'b0) begin n_bad++; $display("[TB] FAIL hold_cycle%0d: ready=%b done=%b err=%b want 0/0/0", i, axis.ready, frame_done, frame_err); end
    end
    axis.valid = 1'b0;
    axis.tlast = 1'b0;
    read_buf(4'd0);
    n_cmp++; if (rd_data !== 8'd0) begin n_bad++; $display("[TB] FAIL hold_buffer0: got %h want 00", rd_data); end
    do_ack();
    n_cmp++; if (axis.ready !== 1'b1) begin n_bad++; $display("[TB] FAIL ack_ready: got %b want 1", axis.ready); end
    for (int i = 0; i < 16; i++) send_beat(8'hA5, i == 15);
    n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("[TB] FAIL a5_done: got %b want 1", frame_done); end
    n_cmp++; if (pix_min !== 8'hA5 || pix_max !== 8'hA5 || pix_sum !== 12'd2640) begin n_bad++; $display("[TB] FAIL a5_stats: min=%h max=%h sum=%0d want a5/a5/2640", pix_min, pix_max, pix_sum); end
    do_ack();
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    n_cmp++; if (axis.ready !== 1'b1) begin n_bad++; $display("[TB] FAIL stray_ack_ready: got %b want 1", axis.ready); end
  endtask

  task automatic test_short_frame();
    for (int i = 0; i < 6; i++) send_beat(8'(10 + i), i == 5);
    n_cmp++; if (frame_err !== 1'b1 || frame_done !== 1'b0) begin n_bad++; $display("[TB] FAIL short_pulse: err=%b done=%b want 1/0", frame_err, frame_done); end
    n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("[TB] FAIL short_count: got %0d want 1", err_count); end
    n_cmp++; if (pix_min !== 8'hA5 || pix_max !== 8'hA5 || pix_sum !== 12'd2640) begin n_bad++; $display("[TB] FAIL short_stats_kept: min=%h max=%h sum=%0d want a5/a5/2640", pix_min, pix_max, pix_sum); end
    @(posedge clk); #1;
    n_cmp++; if (frame_err !== 1'b0 || axis.ready !== 1'b1) begin n_bad++; $display("[TB] FAIL short_after: err=%b ready=%b want 0/1", frame_err, axis.ready); end
    for (int i = 0; i < 16; i++) send_beat(8'(3 * i + 1), i == 15);
    n_cmp++; if (frame_done !== 1'b1 || frame_err !== 1'b0) begin n_bad++; $display("[TB] FAIL short_next_done: done=%b err=%b want 1/0", frame_done, frame_err); end
    n_cmp++; if (pix_min !== 8'd1 || pix_max !== 8'd46 || pix_sum !== 12'd376) begin n_bad++; $display("[TB] FAIL short_next_stats: min=%0d max=%0d sum=%0d want 1/46/376", pix_min, pix_max, pix_sum); end
    do_ack();
  endtask

  task automatic test_long_frame();
    for (int i = 0; i < 20; i++) begin
      send_beat(8'(100 + i), i == 19);
      if (i == 15) begin
        n_cmp++; if (frame_err !== 1'b1 || err_count !== 8'd2) begin n_bad++; $display("[TB] FAIL long_pulse: err=%b count=%0d want 1/2", frame_err, err_count); end
      end
    end
    n_cmp++; if (frame_done !== 1'b0 || frame_err !== 1'b0 || axis.ready !== 1'b1) begin n_bad++; $display("[TB] FAIL long_drain_end: done=%b err=%b ready=%b want 0/0/1", frame_done, frame_err, axis.ready); end
    n_cmp++; if (pix_min !== 8'd1 || pix_max !== 8'd46 || pix_sum !== 12'd376) begin n_bad++; $display("[TB] FAIL long_stats_kept: min=%0d max=%0d sum=%0d want 1/46/376", pix_min, pix_max, pix_sum); end
    read_buf(4'd15);
    n_cmp++; if (rd_data !== 8'd115) begin n_bad++; $display("[TB] FAIL long_buf15: got %0d want 115", rd_data); end
    read_buf(4'd0);
    n_cmp++; if (rd_data !== 8'd100) begin n_bad++; $display("[TB] FAIL long_buf0: got %0d want 100", rd_data); end
    for (int i = 0; i < 16; i++) send_beat(8'(200 - i), i == 15);
    n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("[TB] FAIL long_next_done: got %b want 1", frame_done); end
    n_cmp++; if (pix_min !== 8'd185 || pix_max !== 8'd200 || pix_sum !== 12'd3080) begin n_bad++; $display("[TB] FAIL long_next_stats: min=%0d max=%0d sum=%0d want 185/200/3080", pix_min, pix_max, pix_sum); end
    read_buf(4'd3);
    n_cmp++; if (rd_data !== 8'd197) begin n_bad++; $display("[TB] FAIL long_next_buf3: got %0d want 197", rd_data); end
    do_ack();
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      send_beat(8'(i), i == 15);
    end
    n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("[TB] FAIL gaps_done: got %b want 1", frame_done); end
    n_cmp++; if (pix_min !== 8'd0 || pix_max !== 8'd15 || pix_sum !== 12'd120) begin n_bad++; $display("[TB] FAIL gaps_stats: min=%0d max=%0d sum=%0d want 0/15/120", pix_min, pix_max, pix_sum); end
    read_buf(4'd12);
    n_cmp++; if (rd_data !== 8'd12) begin n_bad++; $display("[TB] FAIL gaps_buf12: got %0d want 12", rd_data); end
    do_ack();
  endtask

  task automatic test_reset_midframe();
    logic saw_err;
    for (int i = 0; i < 10; i++) send_beat(8'(50 + i), 1'b0);
    rst = 1'b1;
    #1;
    n_cmp++; if (axis.ready !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_ready: got %b want 0", axis.ready); end
    @(posedge clk); #1;
    n_cmp++; if ({frame_done, frame_err} !== 2'b00 || {pix_min, pix_max, pix_sum, err_count, rd_data} !== 44'd0) begin n_bad++; $display("[TB] FAIL midrst_outputs: done=%b err=%b min=%h max=%h sum=%0d cnt=%0d rd=%h want all 0", frame_done, frame_err, pix_min, pix_max, pix_sum, err_count, rd_data); end
    rst = 1'b0;
    #1;
    n_cmp++; if (axis.ready !== 1'b1) begin n_bad++; $display("[TB] FAIL midrst_release_ready: got %b want 1", axis.ready); end
    saw_err = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send_beat(8'(2 * i), i == 15);
      if (frame_err === 1'b1) saw_err = 1'b1;
    end
    n_cmp++; if (frame_done !== 1'b1 || saw_err !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_frame: done=%b err_seen=%b want 1/0", frame_done, saw_err); end
    n_cmp++; if (pix_min !== 8'd0 || pix_max !== 8'd30 || pix_sum !== 12'd240 || err_count !== 8'd0) begin n_bad++; $display("[TB] FAIL midrst_stats: min=%0d max=%0d sum=%0d cnt=%0d want 0/30/240/0", pix_min, pix_max, pix_sum, err_count); end
    do_ack();
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst        = 1'b1;
    frame_ack  = 1'b0;
    rd_addr    = 4'd0;
    axis.valid = 1'b0;
    axis.tlast = 1'b0;
    axis.tdata = 8'd0;
    test_reset();
    test_good_frame();
    test_backpressure();
    test_short_frame();
    test_long_frame();
    test_gaps();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
